// File: rtl/decoder_3x8_seq.sv
// Buffered, sequenced 3-to-8 decoder: codes queue in a small FIFO and each
// decoded one-hot word is presented on out for a programmable number of cycles.
module decoder_3x8_seq #(
  parameter int unsigned FIFO_DEPTH = 4,  // power of two, >= 2
  parameter int unsigned HOLD_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [0:2]                    in_code,
  input  logic [HOLD_W-1:0]             hold_len,
  output logic [7:0]                    out,
  output logic                          out_valid,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Code k lights bit (7-k): code 0 -> MSB, code 7 -> LSB.
  function automatic logic [7:0] decode(input logic [2:0] k);
    decode = 8'h80 >> k;
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          out_q, out_d;
  logic                out_valid_q, out_valid_d;

  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [2:0]          code_k;
  logic [2:0]          head;
  logic [HOLD_W-1:0]   hold_eff;

  // Buffer status and handshake, derived only from registered occupancy.
  always_comb begin
    full     = (level_q == LVL_W'(FIFO_DEPTH));
    empty    = (level_q == '0);
    push     = in_valid && !full;
    code_k   = {in_code[0], in_code[1], in_code[2]};
    head     = mem_q[rd_ptr_q];
    hold_eff = (hold_len == '0) ? HOLD_W'(1) : hold_len;
  end

  // Sequencer: pops the head into out and times how long each word is shown.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_d       = 8'h00;
        out_valid_d = 1'b0;
        if (!empty) begin
          pop         = 1'b1;
          out_d       = decode(head);
          out_valid_d = 1'b1;
          cnt_d       = hold_eff;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q > HOLD_W'(1)) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (!empty) begin
          // Back-to-back: next word replaces the current one with no gap.
          pop         = 1'b1;
          out_d       = decode(head);
          out_valid_d = 1'b1;
          cnt_d       = hold_eff;
        end else begin
          out_d       = 8'h00;
          out_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_d       = 8'h00;
        out_valid_d = 1'b0;
        cnt_d       = '0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control and output registers; reset wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Code storage; entries are only read after being written, so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= code_k;
    end
  end

  assign in_ready  = !full;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign level     = level_q;

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Scoreboard bench for decoder_3x8_seq: each accepted code queues its expected
// one-hot word and hold length; a negedge monitor retires them from out.
module tb_decoder_3x8_seq;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned HOLD_W     = 4;
  localparam int unsigned LVL_W      = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [0:2]        in_code;
  logic [HOLD_W-1:0] hold_len;
  logic [7:0]        out;
  logic              out_valid;
  logic [LVL_W-1:0]  level;

  decoder_3x8_seq #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .HOLD_W     (HOLD_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .hold_len  (hold_len),
    .out       (out),
    .out_valid (out_valid),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] word;
    int         hold;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         errors    = 0;
  int         checks    = 0;
  int         remaining = 0;
  logic [7:0] cur_word  = 8'h00;
  int         dummy;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] onehot_of(input logic [2:0] k);
    logic [7:0] w;
    w = 8'h00;
    w[7 - int'(k)] = 1'b1;
    return w;
  endfunction

  // Monitor: every valid cycle must carry the current expected word for its full hold.
  always @(negedge clk) begin
    if (rst) begin
      remaining = 0;
    end else if (out_valid) begin
      if (remaining == 0) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          mon_e     = sb.pop_front();
          cur_word  = mon_e.word;
          remaining = mon_e.hold;
        end
      end
      check("out_word", 32'(out), 32'(cur_word));
      if (remaining > 0) remaining--;
    end else begin
      check("out_idle", 32'(out), 32'd0);
      check("run_len", 32'(remaining), 32'd0);
      remaining = 0;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [2:0] code, input int hold, output int waited);
    exp_t e;
    waited   = 0;
    in_valid = 1'b1;
    in_code  = code;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    e.word = onehot_of(code);
    e.hold = hold;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while ((sb.size() != 0 || remaining != 0 || out_valid) && b < 300) begin
      @(negedge clk);
      b++;
    end
    check("drain", 32'(sb.size() + remaining), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] fill_codes [6];
    int         w;
    int         b;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = 3'b000;
    hold_len = HOLD_W'(1);
    repeat (2) @(negedge clk);
    check("rst_out", 32'(out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single code, hold 3, one-edge latency after the push.
    hold_len = HOLD_W'(3);
    push(3'b010, 3, dummy);
    check("lat_t_valid", 32'(out_valid), 32'd0);
    check("lat_t_level", 32'(level), 32'd1);
    @(negedge clk);
    check("lat_t1_valid", 32'(out_valid), 32'd1);
    check("lat_t1_word", 32'(out), 32'h20);
    check("lat_t1_level", 32'(level), 32'd0);
    drain();

    // All codes back-to-back at hold 1: continuous walk 80..01.
    hold_len = HOLD_W'(1);
    fork
      begin
        for (int i = 0; i < 8; i++) push(3'(i), 1, dummy);
      end
      begin
        b = 0;
        while (!out_valid && b < 20) begin
          @(negedge clk);
          b++;
        end
        for (int j = 0; j < 8; j++) begin
          check("walk_valid", 32'(out_valid), 32'd1);
          check("walk_word", 32'(out), 32'(8'h80 >> j));
          @(negedge clk);
        end
      end
    join
    drain();

    // Full buffer: first pop at edge 1, four more fill it, sixth stalls until
    // the second pop 15 cycles later.
    hold_len = HOLD_W'(15);
    fill_codes = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd4};
    for (int i = 0; i < 5; i++) push(fill_codes[i], 15, dummy);
    check("full_level", 32'(level), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    push(fill_codes[5], 15, w);
    check("full_stall_cycles", 32'(w), 32'd12);
    check("refill_level", 32'(level), 32'd4);
    drain();

    // Simultaneous push and pop at level 2.
    hold_len = HOLD_W'(4);
    push(3'b001, 4, dummy);
    push(3'b110, 4, dummy);
    push(3'b011, 4, dummy);
    check("pp_level_pre", 32'(level), 32'd2);
    repeat (2) @(negedge clk);
    check("pp_level_wait", 32'(level), 32'd2);
    push(3'b100, 4, dummy);
    check("pp_level_post", 32'(level), 32'd2);
    drain();

    // hold_len 0 behaves as 1.
    hold_len = HOLD_W'(0);
    push(3'b111, 1, dummy);
    @(negedge clk);
    check("h0_word", 32'(out), 32'h01);
    check("h0_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("h0_end", 32'(out_valid), 32'd0);
    drain();

    // hold_len changed mid-word does not shorten it.
    hold_len = HOLD_W'(5);
    push(3'b101, 5, dummy);
    @(negedge clk);
    hold_len = HOLD_W'(1);
    drain();

    // Reset during HOLD with three codes buffered, push offered on the reset edge.
    hold_len = HOLD_W'(8);
    for (int i = 0; i < 4; i++) push(3'(2 * i), 8, dummy);
    check("prerst_level", 32'(level), 32'd3);
    check("prerst_valid", 32'(out_valid), 32'd1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_code  = 3'b111;
    sb.delete();
    @(negedge clk);
    sb.delete();
    check("mrst_out", 32'(out), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_level", 32'(level), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(out_valid), 32'd0);
    end
    check("post_rst_level", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_3x8_seq.md
DECODER_3X8_SEQ -- requirements
Module: decoder_3x8_seq

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the input code buffer depth (power of 2, >=2).
REQ-002 The block SHALL have parameter HOLD_W, default 4, giving the width of the hold-length input and counter.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk only.
REQ-004 Port: clk  input  1  system clock, rising edge.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  in_code is presented this cycle.
REQ-007 Port: in_ready  output  1  buffer can accept a code this cycle.
REQ-008 Port: in_code  input  3  code, declared [0:2], index 0 is MSB.
REQ-009 Port: hold_len  input  HOLD_W  cycles each one-hot word is held; sampled at pop time.
REQ-010 Port: out  output  8  registered one-hot decode, [7:0].
REQ-011 Port: out_valid  output  1  out carries a decoded word.
REQ-012 Port: level  output  log2(FIFO_DEPTH)+1  current buffer occupancy.

Function
REQ-013 Mapping SHALL invert the team's 8x3 encoder: code k (0..7) drives out bit (7-k) only; 000 -> 8'b10000000, 111 -> 8'b00000001.
REQ-014 A push SHALL occur on an edge where in_valid && in_ready; in_ready SHALL equal (level != FIFO_DEPTH), from registered state only.
REQ-015 When full, in_ready SHALL be 0 even if a pop occurs that cycle; offered codes are not taken, no overflow or loss.
REQ-016 level SHALL update as level + push - pop each edge; simultaneous push and pop leaves level unchanged; read/write pointers wrap modulo FIFO_DEPTH.
REQ-017 State machine SHALL have two states: IDLE and HOLD.
REQ-018 IDLE: out = 8'h00, out_valid = 0; on an edge with level != 0, pop head, load out with its decode, out_valid = 1, counter = max(hold_len,1), go HOLD.
REQ-019 HOLD: counter decrements each edge while > 1; out and out_valid held constant.
REQ-020 HOLD, counter == 1, level != 0: pop next code that edge, load new decode and counter, stay HOLD (back-to-back, no zero gap).
REQ-021 HOLD, counter == 1, level == 0: out = 8'h00, out_valid = 0, go IDLE.
REQ-022 hold_len == 0 SHALL be treated as 1; maximum hold is 2^HOLD_W - 1 cycles.
REQ-023 Latency: a code pushed at edge t into an empty buffer in IDLE SHALL appear on out after edge t+1 (no bypass path).
REQ-024 A code pushed on the same edge the buffer is read while empty SHALL NOT be popped that edge.
REQ-025 out SHALL be one-hot whenever out_valid = 1 and all-zero whenever out_valid = 0; X is never driven.
REQ-026 hold_len changes during HOLD SHALL NOT affect the word in progress.

Reset
REQ-027 With rst = 1 at an edge: state = IDLE, out = 8'h00, out_valid = 0, level = 0, pointers = 0, counter = 0; in_ready = 1 after that edge.
REQ-028 Reset mid-HOLD or with buffer non-empty SHALL discard all buffered and in-progress codes; rst takes priority over push and pop on the same edge.

Verification
REQ-029 Single code: push 3'b010, hold_len = 3 -> out = 8'b00100000, out_valid = 1 for exactly 3 cycles starting the edge after push, then 8'h00.
REQ-030 All codes: push 000..111 back-to-back, hold_len = 1 -> out walks 8'h80, 8'h40 ... 8'h01 on consecutive cycles, no zero gap, out_valid continuous.
REQ-031 Full: hold_len = 15, push 5 codes with in_valid held high -> level reaches 4, in_ready = 0, 5th code taken only after the first pop.
REQ-032 Simultaneous push/pop at level 2 -> level stays 2, order of codes on out preserved.
REQ-033 hold_len = 0 with code 3'b111 -> out = 8'h01 for exactly 1 cycle.
REQ-034 Assert rst during HOLD with 3 codes buffered -> next cycle out = 8'h00, out_valid = 0, level = 0, in_ready = 1; no buffered code appears afterward.
